rf_scoreboard_mp: RTL and testbench

- Parametrised successor to the decode-stage register file.
- Generalised in data width, register count and number of combinational read ports.
- Two prioritised write ports with write-through bypass.
- Adds a per-register busy scoreboard for hazard detection and a sequential walk-clear engine, so the file can be flushed without a global reset.
- Sits in Decode; read ports feed operand fetch, write ports come from writeback.

---
 rtl/rf_scoreboard_mp.sv | 142 ++++++++++++++
 tb/tb_rf_scoreboard_mp.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard_mp.sv
// Multi-port decode register file with write-through bypass, a per-register
// busy scoreboard and a sequential walk-clear engine for flushing without reset.
module rf_scoreboard_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*AW-1:0]     rd_sel_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr0_en_i,
    input  logic [AW-1:0]            wr0_sel_i,
    input  logic [DATA_W-1:0]        wr0_data_i,
    input  logic                     wr1_en_i,
    input  logic [AW-1:0]            wr1_sel_i,
    input  logic [DATA_W-1:0]        wr1_data_i,
    input  logic                     sb_set_i,
    input  logic [AW-1:0]            sb_set_sel_i,
    input  logic                     clear_i,
    output logic                     clear_busy_o,
    output logic                     clear_done_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e              state_q;
    logic [AW-1:0]       idx_q;
    logic                clear_done_q;
    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic          idle;
    logic          wr0_acc;
    logic          wr1_acc;
    logic          set_acc;
    logic [AW-1:0] rsel;

    function automatic logic is_zero_reg(input logic [AW-1:0] s);
        return (ZERO_REG != 0) && (s == '0);
    endfunction

    // wr1 is dropped when wr0 targets the same register in the same cycle.
    assign idle    = (state_q == ST_IDLE);
    assign wr0_acc = idle && wr0_en_i && !is_zero_reg(wr0_sel_i);
    assign wr1_acc = idle && wr1_en_i && !is_zero_reg(wr1_sel_i)
                     && !(wr0_acc && (wr0_sel_i == wr1_sel_i));
    assign set_acc = idle && sb_set_i && !is_zero_reg(sb_set_sel_i);

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (!idle) begin
            mem_d[idx_q]  = '0;
            busy_d[idx_q] = 1'b0;
        end else begin
            if (wr1_acc) begin
                mem_d[wr1_sel_i]  = wr1_data_i;
                busy_d[wr1_sel_i] = 1'b0;
            end
            if (wr0_acc) begin
                mem_d[wr0_sel_i]  = wr0_data_i;
                busy_d[wr0_sel_i] = 1'b0;
            end
            // A new producer issued alongside a retiring one keeps the register busy.
            if (set_acc) begin
                busy_d[sb_set_sel_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clear_i) begin
                        state_q <= ST_CLEAR;
                        idx_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (idx_q == AW'(NUM_REGS - 1)) begin
                        state_q      <= ST_IDLE;
                        clear_done_q <= 1'b1;
                    end
                    idx_q <= idx_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        rsel      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rsel = rd_sel_i[k*AW +: AW];
            if (is_zero_reg(rsel)) begin
                rd_data_o[k*DATA_W +: DATA_W] = '0;
            end else if (idle && wr0_en_i && (wr0_sel_i == rsel)) begin
                rd_data_o[k*DATA_W +: DATA_W] = wr0_data_i;
            end else if (idle && wr1_en_i && (wr1_sel_i == rsel)) begin
                rd_data_o[k*DATA_W +: DATA_W] = wr1_data_i;
            end else begin
                rd_data_o[k*DATA_W +: DATA_W] = mem_q[rsel];
            end
            rd_busy_o[k] = busy_q[rsel] && !is_zero_reg(rsel)
                           && !(wr0_acc && (wr0_sel_i == rsel))
                           && !(wr1_acc && (wr1_sel_i == rsel));
        end
    end

    assign clear_busy_o = (state_q == ST_CLEAR);
    assign clear_done_o = clear_done_q;

endmodule

// File: tb/tb_rf_scoreboard_mp.sv
// Self-checking bench for rf_scoreboard_mp: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_rf_scoreboard_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_sel;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wr0_en, wr1_en, sb_set, clear;
    logic [AW-1:0]     wr0_sel, wr1_sel, sb_sel;
    logic [DW-1:0]     wr0_data, wr1_data;
    logic              clear_busy, clear_done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: architectural state after each posedge.
    logic [DW-1:0] m_mem [NR];
    bit            m_busy [NR];
    bit            m_clearing;
    int            m_idx;
    bit            m_done;
    bit            chk_en = 1'b0;

    rf_scoreboard_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_sel_i     (rd_sel),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .wr0_en_i     (wr0_en),
        .wr0_sel_i    (wr0_sel),
        .wr0_data_i   (wr0_data),
        .wr1_en_i     (wr1_en),
        .wr1_sel_i    (wr1_sel),
        .wr1_data_i   (wr1_data),
        .sb_set_i     (sb_set),
        .sb_set_sel_i (sb_sel),
        .clear_i      (clear),
        .clear_busy_o (clear_busy),
        .clear_done_o (clear_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic set_sel(input int k, input int s);
        rd_sel[k*AW +: AW] = AW'(s);
    endtask

    task automatic zero_in();
        rst = 0; rd_sel = '0;
        wr0_en = 0; wr0_sel = '0; wr0_data = '0;
        wr1_en = 0; wr1_sel = '0; wr1_data = '0;
        sb_set = 0; sb_sel = '0; clear = 0;
    endtask

    task automatic model_check();
        int s;
        logic [DW-1:0] e_data;
        bit e_busy, wr_hit;
        if (!chk_en) return;
        chk("clear_busy", clear_busy, m_clearing);
        chk("clear_done", clear_done, m_done);
        for (int k = 0; k < NRD; k++) begin
            s = int'(rd_sel[k*AW +: AW]);
            wr_hit = !m_clearing && ((wr0_en && int'(wr0_sel) == s) || (wr1_en && int'(wr1_sel) == s));
            if (s == 0) e_data = '0;
            else if (!m_clearing && wr0_en && int'(wr0_sel) == s) e_data = wr0_data;
            else if (!m_clearing && wr1_en && int'(wr1_sel) == s) e_data = wr1_data;
            else e_data = m_mem[s];
            e_busy = (s != 0) && m_busy[s] && !wr_hit;
            chk($sformatf("rd_data[%0d] sel=%0d", k, s), rd(k), e_data);
            chk($sformatf("rd_busy[%0d] sel=%0d", k, s), rd_busy[k], e_busy);
        end
    endtask

    task automatic model_update();
        bit next_done;
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_mem[r] = '0;
                m_busy[r] = 0;
            end
            m_clearing = 0; m_idx = 0; m_done = 0;
            chk_en = 1'b1;
            return;
        end
        next_done = 0;
        if (m_clearing) begin
            m_mem[m_idx] = '0;
            m_busy[m_idx] = 0;
            if (m_idx == NR - 1) begin
                m_clearing = 0;
                next_done = 1;
            end else begin
                m_idx++;
            end
        end else begin
            if (clear) begin
                m_clearing = 1;
                m_idx = 0;
            end
            // Apply wr1 first so wr0 overwrites it on a shared destination.
            if (wr1_en && wr1_sel != 0) begin
                m_mem[wr1_sel] = wr1_data;
                m_busy[wr1_sel] = 0;
            end
            if (wr0_en && wr0_sel != 0) begin
                m_mem[wr0_sel] = wr0_data;
                m_busy[wr0_sel] = 0;
            end
            if (sb_set && sb_sel != 0) m_busy[sb_sel] = 1;
        end
        m_done = next_done;
    endtask

    task automatic settle();
        #2;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    int busy_cnt, done_cnt, done_at;

    initial begin
        for (int r = 0; r < NR; r++) begin
            m_mem[r] = '0;
            m_busy[r] = 0;
        end
        m_clearing = 0; m_idx = 0; m_done = 0;
        zero_in();
        rst = 1;
        @(negedge clk);
        settle(); tick();
        rst = 1;
        settle(); tick();

        // Reset state
        zero_in(); set_sel(0, 5); set_sel(1, 3);
        settle();
        chk("reset clear_busy", clear_busy, 0);
        chk("reset clear_done", clear_done, 0);
        chk("reset rd0", rd(0), 0);
        chk("reset rd1", rd(1), 0);
        chk("reset busy", rd_busy, 0);
        tick();

        // Bypass then storage
        zero_in(); wr0_en = 1; wr0_sel = 5; wr0_data = 32'hDEADBEEF; set_sel(0, 5);
        settle(); chk("bypass r5", rd(0), 32'hDEADBEEF); tick();
        zero_in(); set_sel(0, 5);
        settle(); chk("stored r5", rd(0), 32'hDEADBEEF); tick();

        // Write-port priority on the same register
        zero_in(); wr0_en = 1; wr0_sel = 7; wr0_data = 32'h11;
        wr1_en = 1; wr1_sel = 7; wr1_data = 32'h22; set_sel(1, 7);
        settle(); chk("prio bypass r7", rd(1), 32'h11); tick();
        zero_in(); set_sel(1, 7);
        settle(); chk("prio stored r7", rd(1), 32'h11); tick();

        // Register zero
        zero_in(); wr0_en = 1; wr0_sel = 0; wr0_data = 32'hFFFF_FFFF; sb_set = 1; sb_sel = 0;
        settle(); chk("r0 bypass", rd(0), 0); chk("r0 busy now", rd_busy[0], 0); tick();
        zero_in();
        settle(); chk("r0 stored", rd(0), 0); chk("r0 busy after", rd_busy[0], 0); tick();

        // Scoreboard
        zero_in(); sb_set = 1; sb_sel = 3; set_sel(0, 3);
        settle(); chk("busy not same-cycle", rd_busy[0], 0); tick();
        zero_in(); set_sel(0, 3);
        settle(); chk("busy r3 set", rd_busy[0], 1); tick();
        zero_in(); wr1_en = 1; wr1_sel = 3; wr1_data = 32'h9; set_sel(0, 3);
        settle(); chk("busy r3 write cycle", rd_busy[0], 0); tick();
        zero_in(); set_sel(0, 3);
        settle(); chk("busy r3 cleared", rd_busy[0], 0); chk("r3 data", rd(0), 32'h9); tick();
        zero_in(); sb_set = 1; sb_sel = 3; wr0_en = 1; wr0_sel = 3; wr0_data = 32'hA; set_sel(0, 3);
        settle(); tick();
        zero_in(); set_sel(0, 3);
        settle(); chk("set wins over write", rd_busy[0], 1); chk("r3 data A", rd(0), 32'hA); tick();

        // Fill and walk-clear
        for (int r = 1; r < NR; r++) begin
            zero_in(); wr0_en = 1; wr0_sel = AW'(r); wr0_data = DW'(r); sb_set = r[0]; sb_sel = AW'(r);
            settle(); tick();
        end
        zero_in(); set_sel(0, 31); set_sel(1, 17);
        settle(); chk("fill r31", rd(0), 31); chk("fill r17", rd(1), 17); tick();
        zero_in(); clear = 1;
        settle(); tick();
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            zero_in();
            set_sel(0, $urandom_range(0, 31)); set_sel(1, $urandom_range(0, 31));
            if (i < 30) begin
                wr0_en = 1; wr0_sel = AW'($urandom_range(1, 31)); wr0_data = $urandom;
                sb_set = 1; sb_sel = AW'($urandom_range(1, 31));
                clear = 1'($urandom_range(0, 1));
            end
            settle();
            if (clear_busy === 1'b1) busy_cnt++;
            if (clear_done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            tick();
        end
        chk("clear busy cycles", busy_cnt, 32);
        chk("clear done pulses", done_cnt, 1);
        chk("clear done position", done_at, 32);
        for (int r = 0; r < NR; r += 2) begin
            zero_in(); set_sel(0, r); set_sel(1, r + 1);
            settle();
            chk($sformatf("cleared r%0d", r), rd(0), 0);
            chk($sformatf("cleared r%0d", r + 1), rd(1), 0);
            chk("cleared busy", rd_busy, 0);
            tick();
        end

        // Reset in the middle of a walk-clear
        for (int r = 1; r < 21; r++) begin
            zero_in(); wr1_en = 1; wr1_sel = AW'(r); wr1_data = DW'(r * 3);
            settle(); tick();
        end
        zero_in(); clear = 1;
        settle(); tick();
        for (int i = 1; i < 10; i++) begin
            zero_in(); settle(); tick();
        end
        zero_in(); rst = 1;
        settle(); chk("mid-clear busy", clear_busy, 1); tick();
        zero_in();
        settle(); chk("abort clear_busy", clear_busy, 0); chk("abort clear_done", clear_done, 0); tick();
        for (int r = 0; r < NR; r += 2) begin
            zero_in(); set_sel(0, r); set_sel(1, r + 1);
            settle();
            chk($sformatf("abort r%0d", r), rd(0), 0);
            chk($sformatf("abort r%0d", r + 1), rd(1), 0);
            chk("abort no done", clear_done, 0);
            tick();
        end
        zero_in(); wr0_en = 1; wr0_sel = 9; wr0_data = 32'h5;
        settle(); tick();
        zero_in(); set_sel(0, 9);
        settle(); chk("post-abort r9", rd(0), 32'h5); tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            zero_in();
            rst      = ($urandom_range(0, 399) == 0);
            clear    = ($urandom_range(0, 79) == 0);
            wr0_en   = 1'($urandom_range(0, 1));
            wr0_sel  = AW'($urandom_range(0, 31));
            wr0_data = $urandom;
            wr1_en   = 1'($urandom_range(0, 1));
            wr1_sel  = ($urandom_range(0, 3) == 0) ? wr0_sel : AW'($urandom_range(0, 31));
            wr1_data = $urandom;
            sb_set   = ($urandom_range(0, 2) == 0);
            sb_sel   = ($urandom_range(0, 3) == 0) ? wr0_sel : AW'($urandom_range(0, 31));
            set_sel(0, ($urandom_range(0, 2) == 0) ? int'(wr0_sel) : $urandom_range(0, 31));
            set_sel(1, ($urandom_range(0, 2) == 0) ? int'(wr1_sel) : $urandom_range(0, 31));
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
